param_fir_filter: RTL

PARAM_FIR_FILTER -- requirements
Module: param_fir_filter

---
 rtl/fir_pkg.sv | 43 ++++
 rtl/fir_round_sat.sv | 29 ++
 rtl/param_fir_filter.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/fir_pkg.sv
// Shared definitions for the time-multiplexed FIR filter.
//   fir_state_e : controller states (idle / multiply-accumulate / output)
//   acc_width() : accumulator width that cannot overflow for a given geometry
//   round_sat() : round-half-up, arithmetic right shift, then clip to a signed width
package fir_pkg;

  typedef enum logic [1:0] {StIdle, StMac, StOut} fir_state_e;

  typedef struct packed {
    logic               sat;
    logic signed [63:0] val;
  } rs_result_t;

  // Sum of TAPS products of DATA_W x COEF_W signed values.
  function automatic int unsigned acc_width(int unsigned data_w, int unsigned coef_w,
                                            int unsigned taps);
    return data_w + coef_w + $clog2(taps);
  endfunction

  // Operates on a 64-bit sign-extended value so one function serves any width up to 64.
  function automatic rs_result_t round_sat(logic signed [63:0] v, int unsigned shift,
                                           int unsigned out_w);
    rs_result_t         res;
    logic signed [63:0] r;
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
    r     = (v + (64'sd1 <<< (shift - 1))) >>> shift;
    max_v = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    min_v = -(64'sd1 <<< (out_w - 1));
    if (r > max_v) begin
      res.val = max_v;
      res.sat = 1'b1;
    end else if (r < min_v) begin
      res.val = min_v;
      res.sat = 1'b1;
    end else begin
      res.val = r;
      res.sat = 1'b0;
    end
    return res;
  endfunction

endpackage

// File: rtl/fir_round_sat.sv
// Rounds and saturates a wide signed value down to the output width.
//   val_i  : signed value, InW bits
//   data_o : round((val_i) / 2^Shift) clipped to signed OutW
//   sat_o  : high when clipping occurred
module fir_round_sat
  import fir_pkg::*;
#(
  parameter int unsigned InW   = 26,
  parameter int unsigned OutW  = 8,
  parameter int unsigned Shift = 6
) (
  input  logic signed [InW-1:0]  val_i,
  output logic signed [OutW-1:0] data_o,
  output logic                   sat_o
);

  rs_result_t res;
  logic       unused_hi;

  always_comb begin
    res = round_sat(64'(val_i), Shift, OutW);
  end

  assign data_o    = res.val[OutW-1:0];
  assign sat_o     = res.sat;
  // Upper bits are a sign extension of data_o after clipping.
  assign unused_hi = ^res.val[63:OutW];

endmodule

// File: rtl/param_fir_filter.sv
// Parameterised FIR filter with a single shared multiplier and an optional integrator.
// A sample is accepted in idle, TAPS multiply-accumulate cycles follow, then one output cycle.
//   clk, reset            : clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready     : sample handshake; in_data is the signed sample
//   coef_we/addr/wdata    : coefficient write port, honoured only while idle
//   mode                  : 0 = plain FIR, 1 = running sum of FIR results
//   integ_clr             : restarts the integrator
//   out_valid             : one-cycle strobe; out_data/out_sat held between strobes
module param_fir_filter
  import fir_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned COEF_W = 8,
  parameter int unsigned TAPS   = 4,
  parameter int unsigned OUT_W  = 8,
  parameter int unsigned SHIFT  = 6
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [DATA_W-1:0]  in_data,
  input  logic                      coef_we,
  input  logic [$clog2(TAPS)-1:0]   coef_addr,
  input  logic signed [COEF_W-1:0]  coef_wdata,
  input  logic                      mode,
  input  logic                      integ_clr,
  output logic                      out_valid,
  output logic signed [OUT_W-1:0]   out_data,
  output logic                      out_sat
);

  localparam int unsigned AddrW = $clog2(TAPS);
  localparam int unsigned AccW  = acc_width(DATA_W, COEF_W, TAPS);
  localparam int unsigned IntW  = AccW + 8;
  localparam int unsigned ProdW = DATA_W + COEF_W;

  fir_state_e                state_q, state_d;
  logic signed [DATA_W-1:0]  dly_q  [TAPS];
  logic signed [DATA_W-1:0]  dly_d  [TAPS];
  logic signed [COEF_W-1:0]  coef_q [TAPS];
  logic signed [COEF_W-1:0]  coef_d [TAPS];
  logic signed [AccW-1:0]    acc_q, acc_d;
  logic signed [IntW-1:0]    integ_q, integ_d;
  logic [AddrW-1:0]          k_q, k_d;
  logic                      out_valid_q, out_valid_d;
  logic signed [OUT_W-1:0]   out_data_q, out_data_d;
  logic                      out_sat_q, out_sat_d;

  logic signed [ProdW-1:0]   prod;
  logic signed [IntW-1:0]    rs_in;
  logic signed [OUT_W-1:0]   rs_data;
  logic                      rs_sat;
  logic                      addr_ok;

  assign prod    = coef_q[k_q] * dly_q[k_q];
  assign addr_ok = (32'(coef_addr) < TAPS);

  // Integrator only moves in the output cycle; a clear elsewhere zeroes it, in the
  // output cycle it restarts from the current result.
  always_comb begin
    integ_d = integ_q;
    if (state_q == StOut) begin
      if (integ_clr) begin
        integ_d = IntW'(acc_q);
      end else if (mode) begin
        integ_d = integ_q + IntW'(acc_q);
      end
    end else if (integ_clr) begin
      integ_d = '0;
    end
  end

  assign rs_in = mode ? integ_d : IntW'(acc_q);

  fir_round_sat #(
    .InW  (IntW),
    .OutW (OUT_W),
    .Shift(SHIFT)
  ) u_round_sat (
    .val_i (rs_in),
    .data_o(rs_data),
    .sat_o (rs_sat)
  );

  always_comb begin
    state_d     = state_q;
    dly_d       = dly_q;
    coef_d      = coef_q;
    acc_d       = acc_q;
    k_d         = k_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    out_sat_d   = out_sat_q;
    unique case (state_q)
      StIdle: begin
        // A write in the accept cycle lands before the first MAC, so it applies to this sample.
        if (coef_we && addr_ok) begin
          coef_d[coef_addr] = coef_wdata;
        end
        if (in_valid) begin
          dly_d[0] = in_data;
          for (int i = 1; i < TAPS; i++) begin
            dly_d[i] = dly_q[i-1];
          end
          acc_d   = '0;
          k_d     = '0;
          state_d = StMac;
        end
      end
      StMac: begin
        acc_d = acc_q + AccW'(prod);
        k_d   = k_q + 1'b1;
        if (k_q == AddrW'(TAPS - 1)) begin
          state_d = StOut;
        end
      end
      StOut: begin
        out_valid_d = 1'b1;
        out_data_d  = rs_data;
        out_sat_d   = rs_sat;
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      acc_q       <= '0;
      integ_q     <= '0;
      k_q         <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
      for (int i = 0; i < TAPS; i++) begin
        dly_q[i]  <= '0;
        coef_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      integ_q     <= integ_d;
      k_q         <= k_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
      for (int i = 0; i < TAPS; i++) begin
        dly_q[i]  <= dly_d[i];
        coef_q[i] <= coef_d[i];
      end
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;

endmodule
